// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the shared regFile write port, with a one-bit-per-register
// scoreboard of outstanding writes for decode RAW-hazard stalls.
module regfile_wb_arbiter #(
    parameter int unsigned width     = 32,
    parameter int unsigned addrWidth = 5,
    parameter int unsigned numReq    = 3
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic [numReq-1:0]           req_valid,
    output logic [numReq-1:0]           req_ready,
    input  logic [numReq*addrWidth-1:0] req_addr,
    input  logic [numReq*width-1:0]     req_data,
    output logic                        wr_en,
    output logic [addrWidth-1:0]        wr_addr,
    output logic [width-1:0]            wr_data,
    input  logic                        issue_valid,
    input  logic [addrWidth-1:0]        issue_addr,
    input  logic [addrWidth-1:0]        rs_addrA,
    input  logic [addrWidth-1:0]        rs_addrB,
    output logic                        busyA,
    output logic                        busyB
);

    localparam int unsigned ptrWidth = (numReq > 1) ? $clog2(numReq) : 1;
    localparam int unsigned numRegs  = 2 ** addrWidth;

    logic [ptrWidth-1:0]  ptr_q, ptr_d;
    logic                 xfer;
    logic [addrWidth-1:0] sel_addr;
    logic [width-1:0]     sel_data;
    logic                 wr_en_q;
    logic [addrWidth-1:0] wr_addr_q;
    logic [width-1:0]     wr_data_q;
    logic [numRegs-1:0]   busy_q, busy_d;

    // Pass 0 scans ptr..numReq-1, pass 1 wraps over 0..ptr-1.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        ptr_d     = ptr_q;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < numReq; i++) begin
                if (!xfer && req_valid[i] && ((pass == 0) == (i >= 32'(ptr_q)))) begin
                    xfer         = 1'b1;
                    req_ready[i] = 1'b1;
                    sel_addr     = req_addr[i*addrWidth +: addrWidth];
                    sel_data     = req_data[i*width +: width];
                    ptr_d        = ptrWidth'((i + 1) % numReq);
                end
            end
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit high.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q <= xfer && (sel_addr != '0);
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busyA   = busy_q[rs_addrA];
    assign busyB   = busy_q[rs_addrB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round-robin order, x0 drop,
// scoreboard RAW/collision behaviour and asynchronous clear.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        clear;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rs_addrA;
    logic [4:0]  rs_addrB;
    logic        busyA;
    logic        busyB;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf [32];

    regfile_wb_arbiter dut (
        .clock       (clock),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rs_addrA    (rs_addrA),
        .rs_addrB    (rs_addrB),
        .busyA       (busyA),
        .busyB       (busyB)
    );

    always #5 clock = ~clock;

    // Downstream regFile model: writes on the negedge inside the write cycle.
    always @(negedge clock) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int gexp[4] = '{0, 1, 2, 0};

        // Reset with arbitrary activity on the inputs
        clear       = 1'b0;
        req_valid   = 3'b111;
        req_addr    = {5'd7, 5'd6, 5'd5};
        req_data    = {32'h3, 32'h2, 32'h1};
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        rs_addrA    = 5'd3;
        rs_addrB    = 5'd5;
        #12;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_busyA", 64'(busyA), 64'd0);
        chk("reset_busyB", 64'(busyB), 64'd0);

        issue_valid = 1'b0;
        clear       = 1'b1;
        req_addr    = {5'd7, 5'd6, 5'd5};
        req_data    = {32'hC, 32'hB, 32'hA};
        #1;
        chk("post_reset_ready", 64'(req_ready), 64'b001);

        // Round-robin with all three requesters valid
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << gexp[k]));
            step();
            chk($sformatf("rr_wr_en_%0d", k), 64'(wr_en), 64'd1);
            chk($sformatf("rr_wr_addr_%0d", k), 64'(wr_addr), 64'(5 + gexp[k]));
            chk($sformatf("rr_wr_data_%0d", k), 64'(wr_data), 64'(32'hA + gexp[k]));
        end
        chk("rr_ready_after", 64'(req_ready), 64'b010);

        // x0 write: consumed, pointer advances, no write enable
        req_valid = 3'b010;
        req_addr  = {5'd7, 5'd0, 5'd5};
        req_data  = {32'hC, 32'hDEAD, 32'hA};
        #1;
        chk("x0_ready", 64'(req_ready), 64'b010);
        step();
        chk("x0_wr_en", 64'(wr_en), 64'd0);
        req_valid = 3'b111;
        #1;
        chk("x0_ptr_next", 64'(req_ready), 64'b100);
        req_valid = 3'b000;
        step();
        chk("idle_wr_en", 64'(wr_en), 64'd0);
        chk("idle_wr_data_hold", 64'(wr_data), 64'hDEAD);

        // Scoreboard RAW on x9 via the load unit
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        step();
        issue_valid = 1'b0;
        rs_addrA    = 5'd9;
        #1;
        chk("raw_busy_set", 64'(busyA), 64'd1);
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd9, 5'd0};
        req_data  = {32'h0, 32'h1234, 32'h0};
        #1;
        chk("raw_ready", 64'(req_ready), 64'b010);
        chk("raw_busy_pre", 64'(busyA), 64'd1);
        step();
        req_valid = 3'b000;
        chk("raw_busy_clr", 64'(busyA), 64'd0);
        chk("raw_wr_en", 64'(wr_en), 64'd1);
        chk("raw_wr_addr", 64'(wr_addr), 64'd9);
        step();
        chk("raw_rf_read", 64'(rf[9]), 64'h1234);

        // Same-cycle set and clear of x4: set wins
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        step();
        rs_addrB  = 5'd4;
        #1;
        chk("col_busy_pre", 64'(busyB), 64'd1);
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd4};
        req_data  = {32'h0, 32'h0, 32'h44};
        #1;
        chk("col_ready", 64'(req_ready), 64'b001);
        step();
        req_valid   = 3'b000;
        issue_valid = 1'b0;
        chk("col_busy_kept", 64'(busyB), 64'd1);
        chk("col_wr_en", 64'(wr_en), 64'd1);
        chk("col_wr_addr", 64'(wr_addr), 64'd4);
        chk("col_wr_data", 64'(wr_data), 64'h44);

        // Async clear while a write is pending and x3 is busy
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        step();
        issue_valid = 1'b0;
        rs_addrA    = 5'd3;
        req_valid   = 3'b010;
        req_addr    = {5'd0, 5'd10, 5'd0};
        req_data    = {32'h0, 32'h77, 32'h0};
        step();
        req_valid = 3'b000;
        chk("ar_pre_wr_en", 64'(wr_en), 64'd1);
        chk("ar_pre_busy", 64'(busyA), 64'd1);
        #1;
        clear = 1'b0;
        #1;
        chk("ar_wr_en", 64'(wr_en), 64'd0);
        chk("ar_wr_addr", 64'(wr_addr), 64'd0);
        chk("ar_wr_data", 64'(wr_data), 64'd0);
        chk("ar_busy", 64'(busyA), 64'd0);
        #1;
        clear     = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("ar_ptr_restart", 64'(req_ready), 64'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the integer register file (regFile) among several write-back sources: ALU, load unit, mul/div. It arbitrates them round-robin and drives regWriteEnable/addrD/dataD from registered outputs. It also keeps a per-register scoreboard of outstanding writes so decode can stall on RAW hazards. It sits between the execute-stage result sources and the regFile write port.

## Interface
- width, 32, data width of a register
- addrWidth, 5, register address width (2**addrWidth registers)
- numReq, 3, number of write-back requesters (index 0 = ALU, 1 = load, 2 = mul/div)

- clock  input  1  system clock; arbitration and scoreboard update on posedge
- clear  input  1  asynchronous, active-low reset
- req_valid  input  numReq  requester i has a result to write
- req_ready  output  numReq  requester i granted this cycle (one-hot or zero)
- req_addr  input  numReq*addrWidth  destination register of requester i, slice [i*addrWidth +: addrWidth]
- req_data  input  numReq*width  result of requester i, slice [i*width +: width]
- wr_en  output  1  to regFile regWriteEnable
- wr_addr  output  addrWidth  to regFile addrD
- wr_data  output  width  to regFile dataD
- issue_valid  input  1  decode issues an instruction that will write issue_addr
- issue_addr  input  addrWidth  destination of the issuing instruction
- rs_addrA  input  addrWidth  decode source A address
- rs_addrB  input  addrWidth  decode source B address
- busyA  output  1  write to rs_addrA outstanding
- busyB  output  1  write to rs_addrB outstanding

## Operation
- Reset (clear low, async): wr_en=0, wr_addr=0, wr_data=0, round-robin pointer=0, all scoreboard bits 0. req_ready is combinational and reads 0 while nothing is valid.
- Arbitration is combinational within a cycle. Search starts at pointer p and goes p, p+1, …, numReq-1, 0, …, p-1. The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0. No valid input means no grant.
- A transfer happens on the posedge when req_valid[i] && req_ready[i].
- On transfer from i:
  - wr_addr <= req_addr[i]
  - wr_data <= req_data[i]
  - wr_en <= (req_addr[i] != 0)
  - pointer <= (i+1) mod numReq
- With no transfer: wr_en <= 0. wr_addr, wr_data and the pointer hold.
- Writes to x0 are accepted and consumed: ready=1 and the pointer advances, but wr_en stays 0 and the scoreboard is untouched.
- Scoreboard: busy[r] for r in 1..2**addrWidth-1; busy[0] is constant 0.
  - Set on posedge when issue_valid && issue_addr==r.
  - Cleared on posedge when a transfer with req_addr==r occurs.
  - Set and clear of the same r in the same cycle: set wins, bit stays 1.
  - Issue to an already-busy r (WAW): the bit stays 1. Tracking is a single bit, not a count.
- busyA = busy[rs_addrA], busyB = busy[rs_addrB]. Both are combinational from the registered bits, with no bypass of a same-cycle clear.
- A requester must hold req_valid, req_addr and req_data stable until its transfer. The arbiter never drops a granted request.

## Timing
- Grant latency: req_ready is asserted in the same cycle as req_valid if that requester wins.
- Write latency: a transfer at posedge T drives wr_en/wr_addr/wr_data for the cycle T..T+1. regFile writes at the negedge inside that cycle.
- Hazard timing: the busy bit clears at posedge T. Decode sees busyA=0 in cycle T..T+1, and the regFile read at posedge T+1 returns the new value because the write occurred at the intervening negedge. No extra stall cycle is needed.
- Throughput: one write per cycle, back-to-back transfers allowed.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… Worst-case wait is numReq-1 cycles.
- clear asserted mid-operation: outputs and state clear immediately (async). Any result pending in the output register is lost, and pending scoreboard bits clear.

## Test plan
- Reset: clear low with arbitrary inputs -> wr_en=0, wr_addr=0, wr_data=0, busyA=busyB=0. After release, req_valid=3'b111 -> req_ready=3'b001.
- Round-robin: hold req_valid=3'b111, addrs 5/6/7, data 0xA/0xB/0xC for 4 cycles -> grants 0,1,2,0. The cycle after each grant shows wr_en=1 and wr_addr=5,6,7,5 with matching data.
- x0 drop: req_valid=3'b010, req_addr[1]=0, data 0xDEAD -> req_ready=3'b010, next cycle wr_en=0, pointer moves to 2 (next all-valid grant goes to requester 2).
- Scoreboard RAW: issue_valid with issue_addr=9, then rs_addrA=9 -> busyA=1. Load transfer to x9 at posedge T -> busyA=0 from T. The regFile read at T+1 returns the load data.
- Set/clear collision: x4 busy, ALU transfer to x4 in the same cycle as issue_valid/issue_addr=4 -> busy[4] stays 1, wr_en=1 with wr_addr=4 next cycle.
- Async reset mid-stream: assert clear between posedges while wr_en=1 and busy[3]=1 -> wr_en, wr_addr and busy[3] go to 0 before the next clock edge. The pointer restarts at 0.
